// File: rtl/mac_accum.sv
// Packet multiply-accumulate collector: sums unsigned 16-bit products per packet with
// saturation, then holds the result until downstream takes it.
//
// state | meaning
// IDLE  | waiting for the first beat of a packet
// ACC   | packet open, accumulating beats
// DONE  | result presented on out_*, upstream stalled
module mac_accum #(
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [7:0]       cnt;
    logic [7:0]       cnt_nxt;
    logic [7:0]       cnt_inc;
    logic             ovf;
    logic             ovf_nxt;
    logic [ACC_W:0]   sum_ext;

    // One spare bit catches the carry that signals saturation.
    assign sum_ext = {1'b0, acc} + (ACC_W+1)'(in_data);
    assign cnt_inc = cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    acc_nxt   = ACC_W'(in_data);
                    cnt_nxt   = 8'd1;
                    ovf_nxt   = 1'b0;
                    state_nxt = (in_last || LEN_MAX == 8'd1) ? DONE : ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    if (sum_ext[ACC_W]) begin
                        acc_nxt = '1;
                        ovf_nxt = 1'b1;
                    end else begin
                        acc_nxt = sum_ext[ACC_W-1:0];
                    end
                    cnt_nxt   = cnt_inc;
                    state_nxt = (in_last || cnt_inc == LEN_MAX) ? DONE : ACC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode registered state only; result fields read zero when idle.
    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign out_sum   = out_valid ? acc : '0;
    assign out_count = out_valid ? cnt : 8'd0;
    assign out_ovf   = out_valid & ovf;

endmodule

// File: tb/tb_mac_accum.sv
// Self-checking bench for mac_accum with a 16-bit accumulator and 4-beat packet limit,
// compared against a plain-arithmetic packet model.
module tb_mac_accum;

    localparam int ACC_W   = 16;
    localparam int MAX_LEN = 4;
    localparam int SAT     = (1 << ACC_W) - 1;

    logic             clk;
    logic             reset;
    logic [15:0]      in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_count;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;

    int vectors    = 0;
    int miscompares = 0;

    int m_sum, m_cnt;
    bit m_ovf, m_active;
    int r_sum, r_cnt;
    bit r_ovf;

    mac_accum #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packet rules: first beat loads, later beats add with clamp, ends on last or MAX_LEN.
    task automatic model_beat(input int d, input bit l, output bit done);
        if (!m_active) begin
            m_sum = d; m_cnt = 1; m_ovf = 0; m_active = 1;
        end else begin
            m_sum = m_sum + d;
            m_cnt = m_cnt + 1;
            if (m_sum > SAT) begin
                m_sum = SAT; m_ovf = 1;
            end
        end
        done = l || (m_cnt == MAX_LEN);
        if (done) begin
            r_sum = m_sum; r_cnt = m_cnt; r_ovf = m_ovf; m_active = 0;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the beat is taken.
    task automatic send(input int d, input bit l, output bit done);
        int n = 0;
        in_valid = 1'b1; in_data = 16'(d); in_last = l;
        while (!in_ready && n < 50) begin
            @(negedge clk); n++;
        end
        vectors++;
        if (!in_ready) begin
            miscompares++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        model_beat(d, l, done);
    endtask

    // Expects the model's result on out_* now, consumes it, and expects IDLE next cycle.
    task automatic take_result(input string tag);
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== r_sum[ACC_W-1:0] || out_count !== r_cnt[7:0]
            || out_ovf !== r_ovf) begin
            miscompares++;
            $display("FAIL %s_result: valid=%0b sum=%0d cnt=%0d ovf=%0b required 1 %0d %0d %0b",
                     tag, out_valid, out_sum, out_count, out_ovf, r_sum, r_cnt, r_ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || out_count !== 8'd0) begin
            miscompares++;
            $display("FAIL %s_release: valid=%0b ready=%0b sum=%0d cnt=%0d required 0 1 0 0",
                     tag, out_valid, in_ready, out_sum, out_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 16'd123; in_last = 1'b1; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_count !== 8'd0
            || out_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%0b valid=%0b sum=%0d cnt=%0d ovf=%0b required 1 0 0 0 0",
                     in_ready, out_valid, out_sum, out_count, out_ovf);
        end
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        m_active = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit d;
        send(100, 0, d);
        send(200, 0, d);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early_valid: out_valid=%0b required 0", out_valid);
        end
        send(300, 1, d);
        take_result("basic");
    endtask

    task automatic test_maxlen();
        bit d;
        for (int i = 0; i < 4; i++) send(1000, 0, d);
        take_result("maxlen");
        send(1000, 0, d);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL maxlen_newpkt: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
        end
        send(5, 1, d);
        take_result("maxlen_next");
    endtask

    task automatic test_saturate();
        bit d;
        send(16'hFFFF, 0, d);
        send(1, 1, d);
        take_result("sat");
        send(5, 1, d);
        take_result("sat_clear");
    endtask

    task automatic test_backpressure();
        bit d;
        send(42, 1, d);
        in_valid = 1'b1; in_data = 16'd77; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'd42 || out_count !== 8'd1) begin
                miscompares++;
                $display("FAIL hold_%0d: valid=%0b ready=%0b sum=%0d cnt=%0d required 1 0 42 1",
                         i, out_valid, in_ready, out_sum, out_count);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release: valid=%0b ready=%0b required 0 1", out_valid, in_ready);
        end
        send(77, 1, d);
        take_result("held_beat");
    endtask

    task automatic test_reset_mid();
        bit d;
        send(11, 0, d);
        send(22, 0, d);
        reset = 1'b1; in_valid = 1'b1; in_data = 16'd999; in_last = 1'b1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        m_active = 0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_acc: valid=%0b ready=%0b required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_priority: out_valid=%0b required 0", out_valid);
        end
        send(7, 1, d);
        take_result("after_rst");
        send(9, 1, d);
        reset = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0) begin
            miscompares++;
            $display("FAIL rst_done: valid=%0b ready=%0b sum=%0d required 0 1 0",
                     out_valid, in_ready, out_sum);
        end
    endtask

    task automatic test_gap();
        bit d;
        send(10, 0, d);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL gap_%0d: valid=%0b ready=%0b required 0 1", i, out_valid, in_ready);
            end
            @(negedge clk);
        end
        send(20, 1, d);
        take_result("gap");
    endtask

    task automatic test_random();
        bit d;
        int dat;
        for (int i = 0; i < 300; i++) begin
            dat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 2000));
            send(dat, $urandom_range(0, 3) == 0, d);
            if (d) begin
                repeat ($urandom_range(0, 3)) begin
                    vectors++;
                    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== r_sum[ACC_W-1:0]) begin
                        miscompares++;
                        $display("FAIL rand_hold_%0d: valid=%0b ready=%0b sum=%0d required 1 0 %0d",
                                 i, out_valid, in_ready, out_sum, r_sum);
                    end
                    @(negedge clk);
                end
                take_result("rand");
            end else begin
                repeat ($urandom_range(0, 2)) begin
                    vectors++;
                    if (out_valid !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rand_gap_%0d: out_valid=%0b required 0", i, out_valid);
                    end
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        m_active = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_maxlen();
        test_saturate();
        test_backpressure();
        test_reset_mid();
        test_gap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 The block SHALL have one clock, clk; reset, named reset, SHALL be synchronous and active-high.
REQ-002 Parameter ACC_W SHALL default to 24 and set the accumulator and out_sum width (legal range 16..32).
REQ-003 Parameter MAX_LEN SHALL default to 16 and set the maximum number of beats per packet (legal range 1..255).
REQ-004 Port clk SHALL be an input, 1 bit wide: rising-edge clock for all state.
REQ-005 Port reset SHALL be an input, 1 bit wide: synchronous active-high reset.
REQ-006 Port in_data SHALL be an input, 16 bits wide: unsigned product from the upstream 8x8 multiplier.
REQ-007 Port in_valid SHALL be an input, 1 bit wide: in_data and in_last are valid.
REQ-008 Port in_last SHALL be an input, 1 bit wide: marks the final beat of a packet.
REQ-009 Port in_ready SHALL be an output, 1 bit wide: the block can accept a beat.
REQ-010 Port out_sum SHALL be an output, ACC_W bits wide: accumulated packet sum.
REQ-011 Port out_count SHALL be an output, 8 bits wide: number of beats summed.
REQ-012 Port out_ovf SHALL be an output, 1 bit wide: saturation occurred in this packet.
REQ-013 Port out_valid SHALL be an output, 1 bit wide: out_sum, out_count and out_ovf are valid.
REQ-014 Port out_ready SHALL be an input, 1 bit wide: downstream accepts the result.

Function
REQ-015 A beat SHALL be accepted only on a rising edge where in_valid and in_ready are both 1; a result SHALL be consumed only on a rising edge where out_valid and out_ready are both 1.
REQ-016 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-017 in_ready SHALL be 1 in IDLE and ACC and 0 in DONE; out_valid SHALL be 1 only in DONE; both outputs SHALL be registered-state decodes with no combinational path from in_valid or out_ready.
REQ-018 On a beat accepted in IDLE, the block SHALL load acc=in_data, cnt=1 and ovf=0, then go to DONE if in_last=1 or MAX_LEN=1, otherwise to ACC.
REQ-019 On a beat accepted in ACC, the block SHALL set acc=sat(acc+in_data) and cnt=cnt+1, then go to DONE if in_last=1 or cnt+1=MAX_LEN, otherwise stay in ACC.
REQ-020 sat() SHALL compute the sum at ACC_W+1 bits; if the sum exceeds 2^ACC_W-1, acc SHALL become all ones and ovf SHALL be set; ovf SHALL stay set (sticky) until the next IDLE load.
REQ-021 In DONE, out_sum=acc, out_count=cnt and out_ovf=ovf SHALL be held stable until the result is consumed, and the block SHALL then return to IDLE.
REQ-022 Latency: out_valid SHALL assert on the first rising edge after the terminating beat is accepted.
REQ-023 In IDLE and ACC, a cycle with in_valid=0 SHALL leave acc, cnt and ovf unchanged; gaps within a packet are legal.
REQ-024 in_valid asserted in DONE SHALL NOT be accepted; the upstream holds the beat until IDLE.
REQ-025 When out_valid=0, out_sum, out_count and out_ovf SHALL be 0.
REQ-026 A packet terminated by MAX_LEN SHALL NOT carry into the next packet; the next accepted beat SHALL start a new packet regardless of its in_last value.

Reset
REQ-027 On a reset edge, state SHALL become IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0 and in_ready=1 on the following cycle.
REQ-028 Reset asserted in ACC or DONE SHALL discard the partial or pending result with no output transfer.
REQ-029 Reset SHALL take priority over a beat or result transfer on the same edge.

Verification
REQ-030 Beats 100, 200, 300 (last on the third) -> one cycle later out_valid=1, out_sum=600, out_count=3, out_ovf=0.
REQ-031 MAX_LEN=4, five beats of 1000 with in_last=0 -> first result out_sum=4000, out_count=4; the fifth beat starts a new packet with cnt=1.
REQ-032 ACC_W=16, beats 0xFFFF then 0x0001 (last) -> out_sum=0xFFFF, out_ovf=1; the next packet of 5 (last) -> out_sum=5, out_ovf=0.
REQ-033 Result pending with out_ready=0 for 5 cycles and in_valid=1 -> outputs stable, in_ready=0, no beat consumed; out_ready=1 -> IDLE next cycle, then the held beat is accepted.
REQ-034 Reset after 2 beats of a 4-beat packet -> no out_valid; a following packet 7 (last) -> out_sum=7, out_count=1.
REQ-035 Beats 10, idle 3 cycles, 20 (last) -> out_sum=30, out_count=2.
